// File: rtl/line_buffer_ctrl_pkg.sv
// Shared types and sizing for the 4-line frame buffer sequencer.
package line_buffer_ctrl_pkg;

  localparam int unsigned LINE_CNT    = 4;
  localparam int unsigned LINE_PTR_W  = 2;
  localparam int unsigned DEF_LINE_AW = 8;

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_DRAIN} r_state_t;

  // Frame length needs one more bit than the word index: 1..2**line_aw.
  function automatic int unsigned len_w(input int unsigned line_aw);
    return line_aw + 1;
  endfunction

  localparam int unsigned DEF_LEN_W = len_w(DEF_LINE_AW);

endpackage

// File: rtl/line_buffer_ctrl_line_counters.sv
// Read/write line pointers and registered full/empty greenflags for the line ring.
module line_counters
  import line_buffer_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_line_incr,
  input  logic                  rd_line_incr,
  output logic [LINE_PTR_W-1:0] wr_line_ptr,
  output logic [LINE_PTR_W-1:0] rd_line_ptr,
  output logic                  wr_greenflag,
  output logic                  rd_greenflag
);

  logic       rst_n;
  logic [2:0] used;
  logic [2:0] used_nxt;

  assign rst_n = rst;

  always_comb begin
    used_nxt = used;
    case ({wr_line_incr, rd_line_incr})
      2'b10:   used_nxt = used + 3'd1;
      2'b01:   used_nxt = used - 3'd1;
      default: used_nxt = used;
    endcase
  end

  // Greenflags come from the next occupancy so they are valid the cycle after a commit/free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_line_ptr  <= '0;
      rd_line_ptr  <= '0;
      used         <= '0;
      wr_greenflag <= 1'b1;
      rd_greenflag <= 1'b0;
    end else begin
      if (wr_line_incr) wr_line_ptr <= wr_line_ptr + LINE_PTR_W'(1);
      if (rd_line_incr) rd_line_ptr <= rd_line_ptr + LINE_PTR_W'(1);
      used         <= used_nxt;
      wr_greenflag <= (used_nxt != 3'(LINE_CNT));
      rd_greenflag <= (used_nxt != 3'd0);
    end
  end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Writes ingress frames into RAM lines and replays committed lines in FIFO order.
module line_buffer_ctrl
  import line_buffer_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned LINE_AW = DEF_LINE_AW,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 mem_wr_en,
  output logic [LINE_AW+1:0]   mem_wr_addr,
  output logic [DATA_W-1:0]    mem_wr_data,
  output logic                 mem_rd_en,
  output logic [LINE_AW+1:0]   mem_rd_addr,
  input  logic [DATA_W-1:0]    mem_rd_data,
  output logic [CNT_W-1:0]     drop_full_cnt,
  output logic [CNT_W-1:0]     drop_ovf_cnt
);

  localparam int unsigned LEN_W = len_w(LINE_AW);
  localparam logic [LEN_W-1:0] LINE_WORDS = {1'b1, {LINE_AW{1'b0}}};

  w_state_t w_state, w_nxt;
  r_state_t r_state, r_nxt;
  logic [LINE_PTR_W-1:0] wr_line_ptr, rd_line_ptr;
  logic wr_greenflag, rd_greenflag, wr_line_incr, rd_line_incr;
  logic full_hit, ovf_hit;
  logic [LEN_W-1:0] widx, w_idx_cur, ridx, rd_idx_cur, rlen;
  logic [LEN_W-1:0] len_tab [LINE_CNT];
  logic rd_is_last, inflight, inflight_last, pop, credit;
  logic [1:0] fifo_cnt, occ;
  logic fifo_wp, fifo_rp;
  logic [DATA_W-1:0] fifo_data [2];
  logic fifo_last [2];

  line_counters u_line_counters (
    .clk          (clk),
    .rst          (rst),
    .wr_line_incr (wr_line_incr),
    .rd_line_incr (rd_line_incr),
    .wr_line_ptr  (wr_line_ptr),
    .rd_line_ptr  (rd_line_ptr),
    .wr_greenflag (wr_greenflag),
    .rd_greenflag (rd_greenflag)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_nxt;
      r_state <= r_nxt;
    end
  end

  always_comb begin
    w_nxt = w_state;
    case (w_state)
      W_IDLE:  if (in_valid) w_nxt = in_last ? W_IDLE : (wr_greenflag ? W_FILL : W_DROP);
      W_FILL:  if (in_valid && in_last) w_nxt = W_IDLE;
               else if (in_valid && widx == LINE_WORDS) w_nxt = W_DROP;
      W_DROP:  if (in_valid && in_last) w_nxt = W_IDLE;
      default: w_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    mem_wr_en    = 1'b0;
    wr_line_incr = 1'b0;
    full_hit     = 1'b0;
    ovf_hit      = 1'b0;
    w_idx_cur    = widx;
    case (w_state)
      W_IDLE: if (in_valid) begin
        w_idx_cur = '0;
        if (wr_greenflag) begin
          mem_wr_en    = 1'b1;
          wr_line_incr = in_last;
        end else begin
          full_hit = 1'b1;
        end
      end
      W_FILL: if (in_valid) begin
        if (widx == LINE_WORDS) begin
          ovf_hit = 1'b1;
        end else begin
          mem_wr_en    = 1'b1;
          wr_line_incr = in_last;
        end
      end
      default: ;
    endcase
  end

  assign mem_wr_addr = {wr_line_ptr, w_idx_cur[LINE_AW-1:0]};
  assign mem_wr_data = in_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      widx          <= '0;
      drop_full_cnt <= '0;
      drop_ovf_cnt  <= '0;
      for (int unsigned i = 0; i < LINE_CNT; i++) len_tab[i] <= '0;
    end else begin
      if (mem_wr_en) widx <= w_idx_cur + LEN_W'(1);
      if (wr_line_incr) len_tab[wr_line_ptr] <= w_idx_cur + LEN_W'(1);
      if (full_hit && drop_full_cnt != '1) drop_full_cnt <= drop_full_cnt + CNT_W'(1);
      if (ovf_hit && drop_ovf_cnt != '1) drop_ovf_cnt <= drop_ovf_cnt + CNT_W'(1);
    end
  end

  // Credit counts words already leaving this cycle so the FIFO sustains 1 word/cycle.
  assign pop    = out_valid && out_ready;
  assign occ    = 2'(inflight) + fifo_cnt - 2'(pop);
  assign credit = (occ < 2'd2);

  always_comb begin
    r_nxt = r_state;
    case (r_state)
      R_IDLE:  if (mem_rd_en) r_nxt = rd_is_last ? R_DRAIN : R_READ;
      R_READ:  if (mem_rd_en && rd_is_last) r_nxt = R_DRAIN;
      R_DRAIN: if (rd_line_incr) r_nxt = R_IDLE;
      default: r_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en    = 1'b0;
    rd_is_last   = 1'b0;
    rd_line_incr = 1'b0;
    rd_idx_cur   = ridx;
    case (r_state)
      R_IDLE: if (rd_greenflag && credit) begin
        mem_rd_en  = 1'b1;
        rd_idx_cur = '0;
        rd_is_last = (len_tab[rd_line_ptr] == LEN_W'(1));
      end
      R_READ: if (credit) begin
        mem_rd_en  = 1'b1;
        rd_is_last = (ridx == rlen - LEN_W'(1));
      end
      R_DRAIN: rd_line_incr = pop && out_last;
      default: ;
    endcase
  end

  assign mem_rd_addr = {rd_line_ptr, rd_idx_cur[LINE_AW-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ridx          <= '0;
      rlen          <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_cnt      <= '0;
      fifo_wp       <= 1'b0;
      fifo_rp       <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (r_state == R_IDLE && mem_rd_en) rlen <= len_tab[rd_line_ptr];
      if (mem_rd_en) ridx <= rd_idx_cur + LEN_W'(1);
      inflight      <= mem_rd_en;
      inflight_last <= mem_rd_en && rd_is_last;
      if (inflight) begin
        fifo_data[fifo_wp] <= mem_rd_data;
        fifo_last[fifo_wp] <= inflight_last;
        fifo_wp            <= ~fifo_wp;
      end
      if (pop) fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + 2'(inflight) - 2'(pop);
    end
  end

  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = fifo_data[fifo_rp];
  assign out_last  = fifo_last[fifo_rp];

endmodule
